ew_fifo_pop_ctrl: RTL and testbench

EW_FIFO_POP_CTRL -- requirements
Module: ew_fifo_pop_ctrl

---
 rtl/ew_fifo_pop_ctrl.sv | 108 ++++++++++
 tb/tb_ew_fifo_pop_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ew_fifo_pop_ctrl.sv
// Pop-side controller: drains a FWFT FIFO into a 2-entry valid/ready skid buffer.
// Define EW_FIFO_POP_CTRL_CNT_EN to build the accepted-word counter (word_cnt).
module ew_fifo_pop_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_pop,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  flush,
   input  logic                  pop_empty,
   input  logic                  pop_error,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  pop_req_n,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]  word_cnt,
   output logic                  err
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  err_q;
   logic                  pop;
   logic                  take;

   // rst_n gates the request so no pop is issued while reset is held
   assign pop_req_n = ~(rst_n & en & ~flush & ~pop_empty & (state_q != TWO));
   assign pop       = ~pop_req_n;
   assign m_valid   = (state_q != EMPTY);
   assign take      = m_valid & m_ready;
   assign m_data    = head_q;
   assign err       = err_q;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (pop) begin
                  state_d = ONE;
                  head_d  = data_out;
               end
            end
            ONE: begin
               if (pop && take) begin
                  head_d = data_out;
               end else if (pop) begin
                  state_d = TWO;
                  skid_d  = data_out;
               end else if (take) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (take) begin
                  state_d = ONE;
                  head_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_pop or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
         err_q   <= err_q | pop_error;
      end
   end

`ifdef EW_FIFO_POP_CTRL_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_pop or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (take && !flush) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign word_cnt = cnt_q;
`else
   assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_ew_fifo_pop_ctrl.sv
// Bench for ew_fifo_pop_ctrl: FIFO stand-in queue, queue-based reference of the
// buffered words, directed scenarios plus randomized traffic.
module tb_ew_fifo_pop_ctrl;

   localparam int DW = 8;
   localparam int CW = 4;
`ifdef EW_FIFO_POP_CTRL_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic          clk_pop = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          flush = 1'b0;
   logic          pop_empty = 1'b1;
   logic          pop_error = 1'b0;
   logic [DW-1:0] data_out = '0;
   logic          pop_req_n;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic [CW-1:0] word_cnt;
   logic          err;

   ew_fifo_pop_ctrl #(
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk_pop  (clk_pop),
      .rst_n    (rst_n),
      .en       (en),
      .flush    (flush),
      .pop_empty(pop_empty),
      .pop_error(pop_error),
      .data_out (data_out),
      .pop_req_n(pop_req_n),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .word_cnt (word_cnt),
      .err      (err)
   );

   always #5 clk_pop = ~clk_pop;

   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] fifo[$];
   logic [DW-1:0] mq[$];
   int unsigned   mcnt = 0;
   bit            merr = 1'b0;
   logic          obs_pop_n;
   logic          obs_valid;
   logic [DW-1:0] obs_data;
   int            dut_pops = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic refresh();
      pop_empty = (fifo.size() == 0);
      data_out  = pop_empty ? '0 : fifo[0];
   endtask

   task automatic exp_cnt(output logic [31:0] v);
      v = CNT_ON ? (mcnt % (1 << CW)) : 0;
   endtask

   // One clock: compare outputs against the reference, then advance it.
   task automatic step();
      bit ep;
      bit tk;
      logic [31:0] ec;
      @(negedge clk_pop);
      refresh();
      #1;
      obs_pop_n = pop_req_n;
      obs_valid = m_valid;
      obs_data  = m_data;
      if (!pop_req_n) dut_pops++;
      ep = rst_n && en && !flush && fifo.size() > 0 && mq.size() < 2;
      tk = mq.size() > 0 && m_ready;
      exp_cnt(ec);
      chk("pop_req_n", pop_req_n, !ep);
      chk("m_valid", m_valid, mq.size() > 0);
      if (mq.size() > 0) chk("m_data", m_data, mq[0]);
      chk("word_cnt", word_cnt, ec);
      chk("err", err, merr);
      @(posedge clk_pop);
      #1;
      if (!rst_n) begin
         mq.delete();
         mcnt = 0;
         merr = 1'b0;
      end else begin
         if (pop_error) merr = 1'b1;
         if (flush) begin
            mq.delete();
         end else begin
            if (tk) begin
               void'(mq.pop_front());
               mcnt++;
            end
            if (ep) mq.push_back(fifo[0]);
         end
         if (ep) void'(fifo.pop_front());
      end
      refresh();
      #1;
   endtask

   task automatic reset_now(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_valid"}, m_valid, 0);
      chk({tag, "_rst_data"}, m_data, 0);
      chk({tag, "_rst_cnt"}, word_cnt, 0);
      chk({tag, "_rst_err"}, err, 0);
      chk({tag, "_rst_pop_n"}, pop_req_n, 1);
      mq.delete();
      mcnt = 0;
      merr = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   task automatic push_seq(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) fifo.push_back(base + DW'(i));
      refresh();
   endtask

   initial begin
      logic [4:0]    pn_tab;
      logic [4:0]    v_tab;
      logic [DW-1:0] d_tab[5];
      logic [DW-1:0] got[$];
      int            p0;

      #1;
      reset_now("init");

      // streaming 0x11,0x22,0x33 with m_ready held high
      fifo.delete();
      fifo.push_back(8'h11);
      fifo.push_back(8'h22);
      fifo.push_back(8'h33);
      refresh();
      en      = 1'b1;
      m_ready = 1'b1;
      pn_tab  = 5'b11000;
      v_tab   = 5'b01110;
      d_tab   = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stream_pop_n", obs_pop_n, pn_tab[i]);
         chk("stream_valid", obs_valid, v_tab[i]);
         if (v_tab[i]) chk("stream_data", obs_data, d_tab[i]);
      end
      chk("stream_cnt", word_cnt, CNT_ON ? 3 : 0);

      // backpressure: 5 words, m_ready low
      reset_now("bp");
      fifo.delete();
      push_seq(8'hA1, 5);
      en      = 1'b1;
      m_ready = 1'b0;
      p0      = dut_pops;
      repeat (4) step();
      chk("bp_pops", dut_pops - p0, 2);
      chk("bp_pop_n", pop_req_n, 1);
      chk("bp_valid", m_valid, 1);
      chk("bp_hold", m_data, 8'hA1);
      m_ready = 1'b1;
      got.delete();
      repeat (8) begin
         step();
         if (obs_valid) got.push_back(obs_data);
      end
      chk("bp_count", got.size(), 5);
      for (int i = 0; i < got.size() && i < 5; i++)
         chk("bp_order", got[i], 8'hA1 + DW'(i));

      // flush from TWO while m_ready is high
      reset_now("fl");
      fifo.delete();
      push_seq(8'hB1, 4);
      en      = 1'b1;
      m_ready = 1'b0;
      repeat (3) step();
      flush   = 1'b1;
      m_ready = 1'b1;
      p0      = dut_pops;
      step();
      flush = 1'b0;
      chk("flush_nopop", dut_pops - p0, 0);
      chk("flush_valid", m_valid, 0);
      chk("flush_cnt", word_cnt, 0);
      repeat (4) step();

      // sticky error, survives flush
      pop_error = 1'b1;
      step();
      pop_error = 1'b0;
      chk("err_set", err, 1);
      repeat (3) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("err_sticky", err, 1);

      // reset mid-stream
      push_seq(8'hC1, 6);
      en      = 1'b1;
      m_ready = 1'b1;
      repeat (2) step();
      reset_now("mid");
      repeat (8) step();

      // counter wrap: 17 takes on a 4-bit counter
      reset_now("wrap");
      fifo.delete();
      push_seq(8'h40, 17);
      en      = 1'b1;
      m_ready = 1'b1;
      repeat (20) step();
      chk("wrap_cnt", word_cnt, CNT_ON ? 1 : 0);

      // m_ready toggling every cycle
      push_seq(8'h80, 12);
      repeat (40) begin
         m_ready = ~m_ready;
         step();
      end

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         en        = ($urandom_range(0, 9) != 0);
         m_ready   = ($urandom_range(0, 1) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         pop_error = ($urandom_range(0, 199) == 0);
         if (fifo.size() < 8 && $urandom_range(0, 2) != 0)
            fifo.push_back(DW'($urandom));
         refresh();
         step();
      end
      flush     = 1'b0;
      pop_error = 1'b0;
      m_ready   = 1'b1;
      repeat (12) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
